// File: rtl/chunked_adder.sv
`timescale 1ns/1ps
// Multi-cycle adder/subtractor: processes CHUNK bits per cycle, LSB chunk first,
// carrying between chunks in a register. start/ready/done handshake.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carry_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic             last_chunk;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CHUNK:0]   chunk_res;

  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  endfunction

  // Two's-complement overflow: like-signed operands giving a result of the other sign.
  function automatic logic signed_overflow(input logic a_msb,
                                           input logic b_msb,
                                           input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign accept     = (state_q == IDLE) && start;
  assign last_chunk = (state_q == BUSY) && (cnt_q == LAST_CNT);
  assign ready      = (state_q == IDLE);
  assign done       = (state_q == DONE);

  // Operands shift right each BUSY cycle, so the active chunk is always bits [CHUNK-1:0].
  assign chunk_res = add_chunk(a_q[CHUNK-1:0], b_q[CHUNK-1:0], carry_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (last_chunk) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= B ^ {WIDTH{sub}};
      carry_q <= sub | carry_in;
      cnt_q   <= '0;
    end else if (state_q == BUSY) begin
      a_q                             <= a_q >> CHUNK;
      b_q                             <= b_q >> CHUNK;
      carry_q                         <= chunk_res[CHUNK];
      sum[int'(cnt_q)*CHUNK +: CHUNK] <= chunk_res[CHUNK-1:0];
      cnt_q                           <= cnt_q + 1'b1;
      if (last_chunk) begin
        carry_out <= chunk_res[CHUNK];
        overflow  <= signed_overflow(a_q[CHUNK-1], b_q[CHUNK-1], chunk_res[CHUNK-1]);
      end
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
`timescale 1ns/1ps
// Bench for chunked_adder: three instances (4/1, 32/8, 16/16) checked each cycle
// against an arithmetic reference model, plus directed literal vectors.
module tb_chunked_adder;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        in_start[3];
  logic        in_sub[3];
  logic        in_cin[3];
  logic [31:0] in_a[3];
  logic [31:0] in_b[3];

  logic        out_ready[3];
  logic        out_done[3];
  logic        out_cout[3];
  logic        out_ovf[3];
  logic [31:0] out_sum[3];
  logic [3:0]  sum0;
  logic [31:0] sum1;
  logic [15:0] sum2;

  assign out_sum[0] = {28'd0, sum0};
  assign out_sum[1] = sum1;
  assign out_sum[2] = {16'd0, sum2};

  chunked_adder #(.WIDTH(4), .CHUNK(1)) u_w4 (
    .clock(clock), .reset_n(reset_n), .start(in_start[0]), .sub(in_sub[0]),
    .A(in_a[0][3:0]), .B(in_b[0][3:0]), .carry_in(in_cin[0]),
    .ready(out_ready[0]), .done(out_done[0]), .sum(sum0),
    .carry_out(out_cout[0]), .overflow(out_ovf[0]));

  chunked_adder #(.WIDTH(32), .CHUNK(8)) u_w32 (
    .clock(clock), .reset_n(reset_n), .start(in_start[1]), .sub(in_sub[1]),
    .A(in_a[1]), .B(in_b[1]), .carry_in(in_cin[1]),
    .ready(out_ready[1]), .done(out_done[1]), .sum(sum1),
    .carry_out(out_cout[1]), .overflow(out_ovf[1]));

  chunked_adder #(.WIDTH(16), .CHUNK(16)) u_w16 (
    .clock(clock), .reset_n(reset_n), .start(in_start[2]), .sub(in_sub[2]),
    .A(in_a[2][15:0]), .B(in_b[2][15:0]), .carry_in(in_cin[2]),
    .ready(out_ready[2]), .done(out_done[2]), .sum(sum2),
    .carry_out(out_cout[2]), .overflow(out_ovf[2]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nch(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int wid(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 32 : 16);
  endfunction

  // Reference result {overflow, carry_out, sum} from plain arithmetic.
  function automatic logic [33:0] golden(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic s, input logic c);
    logic [31:0] mask, am, bm, sm;
    logic [32:0] full;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am   = a & mask;
    bm   = (s ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bm} + {32'd0, (s ? 1'b1 : c)};
    sm   = full[31:0] & mask;
    return {(am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]), full[w], sm};
  endfunction

  // Model: phase = -1 when idle, else edges elapsed since accept (done at phase == NCHUNK).
  int          phase[3] = '{-1, -1, -1};
  logic [31:0] exp_sum[3];
  logic        exp_cout[3];
  logic        exp_ovf[3];
  logic [33:0] model_r;

  always @(posedge clock or negedge reset_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        phase[i]    = -1;
        exp_sum[i]  = 32'd0;
        exp_cout[i] = 1'b0;
        exp_ovf[i]  = 1'b0;
      end else if (phase[i] < 0) begin
        if (in_start[i]) begin
          model_r = golden(wid(i), in_a[i], in_b[i], in_sub[i], in_cin[i]);
          exp_ovf[i]  = model_r[33];
          exp_cout[i] = model_r[32];
          exp_sum[i]  = model_r[31:0];
          phase[i]    = 0;
        end
      end else if (phase[i] == nch(i)) begin
        phase[i] = -1;
      end else begin
        phase[i] = phase[i] + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("ready[%0d]", i), {31'd0, out_ready[i]}, {31'd0, phase[i] < 0});
        chk($sformatf("done[%0d]", i), {31'd0, out_done[i]}, {31'd0, phase[i] == nch(i)});
        if (phase[i] < 0 || phase[i] == nch(i)) begin
          chk($sformatf("sum[%0d]", i), out_sum[i], exp_sum[i]);
          chk($sformatf("carry_out[%0d]", i), {31'd0, out_cout[i]}, {31'd0, exp_cout[i]});
          chk($sformatf("overflow[%0d]", i), {31'd0, out_ovf[i]}, {31'd0, exp_ovf[i]});
        end
      end
    end
  end

  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c);
    in_a[i]     = a;
    in_b[i]     = b;
    in_sub[i]   = s;
    in_cin[i]   = c;
    in_start[i] = 1'b1;
    @(negedge clock);
    in_start[i] = 1'b0;
    repeat (nch(i) + 1) @(negedge clock);
  endtask

  task automatic check_lit(input int i, input string name, input logic [31:0] s,
                           input logic co, input logic ov);
    chk({name, " sum"}, out_sum[i], s);
    chk({name, " carry_out"}, {31'd0, out_cout[i]}, {31'd0, co});
    chk({name, " overflow"}, {31'd0, out_ovf[i]}, {31'd0, ov});
    chk({name, " model sum"}, exp_sum[i], s);
    chk({name, " model carry_out"}, {31'd0, exp_cout[i]}, {31'd0, co});
    chk({name, " model overflow"}, {31'd0, exp_ovf[i]}, {31'd0, ov});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ndone;
    for (int i = 0; i < 3; i++) begin
      in_start[i] = 1'b0;
      in_sub[i]   = 1'b0;
      in_cin[i]   = 1'b0;
      in_a[i]     = 32'd0;
      in_b[i]     = 32'd0;
    end
    repeat (2) @(negedge clock);
    chk("reset ready", {31'd0, out_ready[1]}, 32'd1);
    chk("reset done", {31'd0, out_done[1]}, 32'd0);
    chk("reset sum", out_sum[1], 32'd0);
    chk("reset carry_out", {31'd0, out_cout[1]}, 32'd0);
    chk("reset overflow", {31'd0, out_ovf[1]}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 4-bit, 1 bit per cycle
    run_op(0, 32'hF, 32'h1, 1'b0, 1'b1);
    check_lit(0, "w4 F+1+1", 32'h1, 1'b1, 1'b0);
    run_op(0, 32'h3, 32'h5, 1'b1, 1'b0);
    check_lit(0, "w4 3-5", 32'hE, 1'b0, 1'b0);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int s = 0; s < 2; s++)
          for (int c = 0; c < 2; c++)
            run_op(0, 32'(a), 32'(b), 1'(s), 1'(c));

    // 32-bit, 8 bits per cycle
    run_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check_lit(1, "w32 ripple", 32'h0000_0000, 1'b1, 1'b0);
    run_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check_lit(1, "w32 pos ovf", 32'h8000_0000, 1'b0, 1'b1);
    run_op(1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
    check_lit(1, "w32 5-7", 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op(1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    check_lit(1, "w32 neg ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);

    // 16-bit single chunk
    run_op(2, 32'h1234, 32'hEDCC, 1'b0, 1'b0);
    check_lit(2, "w16 single", 32'h0000, 1'b1, 1'b0);

    // start pulses during BUSY/DONE and operand changes after accept are ignored
    in_a[1] = 32'h0000_FFFF; in_b[1] = 32'h0000_0001; in_sub[1] = 1'b0; in_cin[1] = 1'b0;
    in_start[1] = 1'b1;
    @(negedge clock);
    in_start[1] = 1'b0;
    @(negedge clock);
    in_start[1] = 1'b1; in_a[1] = 32'hDEAD_BEEF; in_b[1] = 32'h1234_5678;
    @(negedge clock);
    in_start[1] = 1'b0;
    repeat (2) @(negedge clock);
    chk("pulse done", {31'd0, out_done[1]}, 32'd1);
    check_lit(1, "pulse result", 32'h0001_0000, 1'b0, 1'b0);
    in_start[1] = 1'b1;
    @(negedge clock);
    in_start[1] = 1'b0;
    chk("pulse ready", {31'd0, out_ready[1]}, 32'd1);
    chk("pulse sum held", out_sum[1], 32'h0001_0000);
    @(negedge clock);

    // start held high: one accept every NCHUNK+2 cycles
    ndone = 0;
    in_start[1] = 1'b1;
    repeat (24) begin
      @(negedge clock);
      if (out_done[1]) ndone++;
      in_a[1]   = $urandom;
      in_b[1]   = $urandom;
      in_sub[1] = 1'($urandom_range(0, 1));
      in_cin[1] = 1'($urandom_range(0, 1));
    end
    in_start[1] = 1'b0;
    chk("held start done count", 32'(ndone), 32'd4);
    repeat (6) @(negedge clock);

    // asynchronous reset after the second chunk
    in_a[1] = 32'h1111_1111; in_b[1] = 32'h2222_2222; in_sub[1] = 1'b0; in_cin[1] = 1'b0;
    in_start[1] = 1'b1;
    @(negedge clock);
    in_start[1] = 1'b0;
    repeat (2) @(negedge clock);
    chk("partial sum low half", {16'd0, out_sum[1][15:0]}, 32'h3333);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset ready", {31'd0, out_ready[1]}, 32'd1);
    chk("async reset done", {31'd0, out_done[1]}, 32'd0);
    chk("async reset sum", out_sum[1], 32'd0);
    chk("async reset carry_out", {31'd0, out_cout[1]}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_op(1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    check_lit(1, "after reset", 32'h3333_3333, 1'b0, 1'b0);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
